// File: rtl/spart_pkg.sv
// Shared SPART definitions: bus address codes and transmitter state encodings,
// used by the transmitter, receiver and bus interface.
package spart_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IO_XFER   = 2'b00,
    REG_RD    = 2'b01,
    LD_DIV_LO = 2'b10,
    LD_DIV_HI = 2'b11
  } ioaddr_e;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'b00,
    TX_START = 2'b01,
    TX_DATA  = 2'b10,
    TX_STOP  = 2'b11
  } tx_state_e;

  function automatic logic addr_is(input logic [1:0] addr, input ioaddr_e code);
    return addr == code;
  endfunction

endpackage

// File: rtl/spart_tx.sv
// SPART transmitter: one-byte holding register feeding a shift register that
// serialises 8N1 frames on txd, one bit per rate_en pulse.
module spart_tx
  import spart_pkg::*;
#(
  parameter int DATA_BITS = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              iocs,
  input  logic              iorw,
  input  logic [1:0]        ioaddr,
  input  logic [BYTE_W-1:0] bus_in,
  input  logic              rate_en,
  output logic              txd,
  output logic              tbr,
  output logic              tx_busy,
  output logic              tx_ovr
);

  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  tx_state_e         state_q, state_d;
  logic [BYTE_W-1:0] shifter_q, shifter_d;
  logic [BYTE_W-1:0] hold_q, hold_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic              hold_valid_q, hold_valid_d;
  logic              txd_q, txd_d;
  logic              tbr_q, tbr_d;
  logic              tx_ovr_q, tx_ovr_d;

  logic wr;
  logic rd_status;
  logic load;
  logic ovr_set;

  assign wr        = iocs & ~iorw & addr_is(ioaddr, IO_XFER);
  assign rd_status = iocs &  iorw & addr_is(ioaddr, REG_RD);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= TX_IDLE;
      shifter_q    <= '0;
      hold_q       <= '0;
      bit_cnt_q    <= '0;
      hold_valid_q <= 1'b0;
      txd_q        <= 1'b1;
      tbr_q        <= 1'b1;
      tx_ovr_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      shifter_q    <= shifter_d;
      hold_q       <= hold_d;
      bit_cnt_q    <= bit_cnt_d;
      hold_valid_q <= hold_valid_d;
      txd_q        <= txd_d;
      tbr_q        <= tbr_d;
      tx_ovr_q     <= tx_ovr_d;
    end
  end

  // Frame sequencer: every transition is gated by rate_en.
  always_comb begin
    state_d   = state_q;
    shifter_d = shifter_q;
    bit_cnt_d = bit_cnt_q;
    txd_d     = txd_q;
    load      = 1'b0;
    case (state_q)
      TX_IDLE: begin
        txd_d = 1'b1;
        if (hold_valid_q && rate_en) begin
          load      = 1'b1;
          shifter_d = hold_q;
          txd_d     = 1'b0;
          state_d   = TX_START;
        end
      end
      TX_START: begin
        if (rate_en) begin
          txd_d     = shifter_q[0];
          shifter_d = {1'b0, shifter_q[BYTE_W-1:1]};
          bit_cnt_d = '0;
          state_d   = TX_DATA;
        end
      end
      TX_DATA: begin
        if (rate_en) begin
          if (bit_cnt_q == LAST_BIT) begin
            txd_d   = 1'b1;
            state_d = TX_STOP;
          end else begin
            txd_d     = shifter_q[0];
            shifter_d = {1'b0, shifter_q[BYTE_W-1:1]};
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
      TX_STOP: begin
        if (rate_en) begin
          if (hold_valid_q) begin
            // Back-to-back: the next start bit follows the stop bit directly.
            load      = 1'b1;
            shifter_d = hold_q;
            txd_d     = 1'b0;
            state_d   = TX_START;
          end else begin
            txd_d   = 1'b1;
            state_d = TX_IDLE;
          end
        end
      end
      default: begin
        txd_d   = 1'b1;
        state_d = TX_IDLE;
      end
    endcase
  end

  // Holding register; a write coinciding with a load refills it immediately.
  always_comb begin
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    ovr_set      = 1'b0;
    if (load) begin
      hold_valid_d = 1'b0;
    end
    if (wr) begin
      if (!hold_valid_q || load) begin
        hold_d       = bus_in;
        hold_valid_d = 1'b1;
      end else begin
        ovr_set = 1'b1;
      end
    end
    if (ovr_set) begin
      tx_ovr_d = 1'b1;
    end else if (rd_status) begin
      tx_ovr_d = 1'b0;
    end else begin
      tx_ovr_d = tx_ovr_q;
    end
    tbr_d = ~hold_valid_d;
  end

  assign txd     = txd_q;
  assign tbr     = tbr_q;
  assign tx_busy = (state_q != TX_IDLE);
  assign tx_ovr  = tx_ovr_q;

endmodule

// File: tb/tb_spart_tx.sv
// Directed bench for spart_tx: expected bytes are queued as they are written and
// checked against frames decoded from txd at each rate_en pulse.
module tb_spart_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic       iocs;
  logic       iorw;
  logic [1:0] ioaddr;
  logic [7:0] bus_in;
  logic       rate_en;
  logic       txd;
  logic       tbr;
  logic       tx_busy;
  logic       tx_ovr;

  int         vectors     = 0;
  int         miscompares = 0;
  int         frames      = 0;
  int         base;
  int         rcnt        = 0;
  logic [7:0] sb[$];
  int         gaps[$];

  spart_tx #(.DATA_BITS(8)) dut (
    .clk    (clk),
    .rst    (rst),
    .iocs   (iocs),
    .iorw   (iorw),
    .ioaddr (ioaddr),
    .bus_in (bus_in),
    .rate_en(rate_en),
    .txd    (txd),
    .tbr    (tbr),
    .tx_busy(tx_busy),
    .tx_ovr (tx_ovr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // rate_en: one-clock pulse every 16 clocks, changing just after posedge.
  initial begin
    rate_en = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      rcnt    = (rcnt == 15) ? 0 : rcnt + 1;
      rate_en = (rcnt == 15);
    end
  end

  // Frame decoder: txd during a rate_en cycle is the bit of the period now ending.
  initial begin : monitor
    int         mstate;
    int         nbits;
    int         idle_cnt;
    logic [7:0] mdata;
    logic [7:0] exp_b;
    mstate   = 0;
    nbits    = 0;
    idle_cnt = 0;
    mdata    = '0;
    forever begin
      @(negedge clk);
      if (rst !== 1'b1) begin
        mstate   = 0;
        nbits    = 0;
        idle_cnt = 0;
      end else if (rate_en) begin
        case (mstate)
          0: begin
            if (txd === 1'b0) begin
              gaps.push_back(idle_cnt);
              mstate = 1;
              nbits  = 0;
            end else begin
              idle_cnt++;
            end
          end
          1: begin
            mdata[nbits] = txd;
            nbits++;
            if (nbits == 8) mstate = 2;
          end
          default: begin
            check("stop_bit", 32'(txd), 32'd1);
            check("frame_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
              exp_b = sb.pop_front();
              check("frame_byte", 32'(mdata), 32'(exp_b));
            end
            frames++;
            idle_cnt = 0;
            mstate   = 0;
          end
        endcase
      end
    end
  end

  task automatic idle_bus();
    iocs   = 1'b0;
    iorw   = 1'b0;
    ioaddr = 2'b00;
    bus_in = 8'h00;
  endtask

  task automatic bus_write_now(input logic [7:0] b, input logic accept);
    iocs   = 1'b1;
    iorw   = 1'b0;
    ioaddr = 2'b00;
    bus_in = b;
    if (accept) sb.push_back(b);
    @(negedge clk);
    idle_bus();
  endtask

  task automatic bus_write(input logic [7:0] b, input logic accept);
    @(negedge clk);
    bus_write_now(b, accept);
  endtask

  task automatic wait_sig(input int which, input logic val, input string tag);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      @(negedge clk);
      case (which)
        0:       found = (txd === val);
        1:       found = (tx_busy === val);
        default: found = (rate_en === val);
      endcase
    end
    check(tag, 32'(found), 32'd1);
  endtask

  task automatic wait_frames(input int n, input string tag);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 3000 && !found; i++) begin
      @(negedge clk);
      found = (frames >= n);
    end
    check(tag, 32'(found), 32'd1);
  endtask

  initial begin
    idle_bus();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_state", 32'({txd, tbr, tx_busy, tx_ovr}), 32'h0000_000C);
    rst = 1'b1;

    // Idle with no writes: rate_en must not start a frame.
    for (int i = 0; i < 8; i++) begin
      repeat (8) @(negedge clk);
      check("t1_idle", 32'({txd, tbr, tx_busy, tx_ovr}), 32'h0000_000C);
    end

    // Single byte 0xA5.
    check("t2_tbr_before", 32'(tbr), 32'd1);
    bus_write(8'hA5, 1'b1);
    check("t2_tbr_drop", 32'(tbr), 32'd0);
    check("t2_not_busy_yet", 32'(tx_busy), 32'd0);
    wait_sig(0, 1'b0, "t2_start_bit");
    check("t2_tbr_at_start", 32'(tbr), 32'd1);
    check("t2_busy", 32'(tx_busy), 32'd1);
    wait_frames(1, "t2_frame_done");

    // 0x3C then 0xFF during its data bits: contiguous frames.
    base = frames;
    bus_write(8'h3C, 1'b1);
    wait_sig(1, 1'b1, "t3_busy");
    for (int i = 0; i < 3; i++) wait_sig(2, 1'b1, "t3_rate");
    bus_write(8'hFF, 1'b1);
    check("t3_tbr_full", 32'(tbr), 32'd0);
    wait_frames(base + 2, "t3_frames_done");
    check("t3_no_gap", 32'(gaps[gaps.size()-1]), 32'd0);
    check("t3_no_ovr", 32'(tx_ovr), 32'd0);

    // Overrun: third byte dropped, then status read clears the flag.
    wait_sig(1, 1'b0, "t4_idle");
    base = frames;
    bus_write(8'h11, 1'b1);
    wait_sig(1, 1'b1, "t4_busy");
    bus_write(8'h22, 1'b1);
    check("t4_ovr_clear", 32'(tx_ovr), 32'd0);
    bus_write(8'h33, 1'b0);
    check("t4_ovr_set", 32'(tx_ovr), 32'd1);
    check("t4_tbr_full", 32'(tbr), 32'd0);
    @(negedge clk);
    iocs   = 1'b1;
    iorw   = 1'b1;
    ioaddr = 2'b01;
    @(negedge clk);
    idle_bus();
    check("t4_ovr_cleared", 32'(tx_ovr), 32'd0);
    wait_frames(base + 2, "t4_frames_done");
    check("t4_no_gap", 32'(gaps[gaps.size()-1]), 32'd0);
    // Divisor writes and IO_XFER reads leave the transmitter alone.
    @(negedge clk);
    iocs   = 1'b1;
    iorw   = 1'b0;
    ioaddr = 2'b10;
    bus_in = 8'h55;
    @(negedge clk);
    iorw   = 1'b1;
    ioaddr = 2'b00;
    @(negedge clk);
    idle_bus();
    check("t4_other_addr", 32'({tbr, tx_ovr}), 32'h0000_0002);

    // Asynchronous reset during data bit 4 of 0x81.
    wait_sig(1, 1'b0, "t5_idle");
    bus_write(8'h81, 1'b1);
    wait_sig(0, 1'b0, "t5_start");
    for (int i = 0; i < 5; i++) wait_sig(2, 1'b1, "t5_rate");
    repeat (4) @(negedge clk);
    check("t5_bit4", 32'(txd), 32'd0);
    #2 rst = 1'b0;
    #1;
    check("t5_async_reset", 32'({txd, tbr, tx_busy}), 32'h0000_0006);
    sb.delete();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    base = frames;
    bus_write(8'h81, 1'b1);
    wait_frames(base + 1, "t5_frame_done");

    // Write landing in the very cycle IDLE loads the shifter.
    wait_sig(1, 1'b0, "t6_idle");
    base = frames;
    wait_sig(2, 1'b1, "t6_rate_a");
    bus_write(8'h5A, 1'b1);
    wait_sig(2, 1'b1, "t6_rate_b");
    bus_write_now(8'hC3, 1'b1);
    check("t6_tbr_held", 32'(tbr), 32'd0);
    check("t6_busy", 32'(tx_busy), 32'd1);
    check("t6_no_ovr", 32'(tx_ovr), 32'd0);
    wait_frames(base + 2, "t6_frames_done");
    check("t6_no_gap", 32'(gaps[gaps.size()-1]), 32'd0);

    wait_sig(1, 1'b0, "end_idle");
    check("sb_drained", 32'(sb.size()), 32'd0);
    check("end_state", 32'({txd, tbr, tx_busy, tx_ovr}), 32'h0000_000C);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
